io_writeback_arbiter: RTL and testbench

Merges writeback responses from up to `PORTCOUNT` IO device controllers (GPIO, timers, UART, …) into the single CPU writeback channel (`WritebackREQ/ACK/DestReg/Data`). It sits between the device-side `IOIn_*` interfaces and the CPU writeback port, on the system clock. It arbitrates round-robin and holds the winner in a one-entry output buffer. Responses flagged as completion-only (no register or memory response) are acknowledged and dropped, and counted.

---
 rtl/io_pkg.sv | 19 +
 rtl/round_robin_select.sv | 38 +++
 rtl/io_writeback_arbiter.sv | 108 ++++++++++
 tb/tb_io_writeback_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared IO-side types: writeback entry layout and output-buffer state encoding.
package io_pkg;

    localparam int unsigned IODESTREGBITS  = 4;
    localparam int unsigned IODATABITWIDTH = 16;

    typedef struct packed {
        logic                      RegFlag;
        logic                      MemFlag;
        logic [IODESTREGBITS-1:0]  DestReg;
        logic [IODATABITWIDTH-1:0] Data;
    } IOWriteback_t;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } wb_buf_state_e;

endpackage

// File: rtl/round_robin_select.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping.
module round_robin_select #(
    parameter int unsigned N    = 4,
    parameter int unsigned PTRW = 2
) (
    input  logic [N-1:0]    req_i,
    input  logic [PTRW-1:0] ptr_i,
    output logic [N-1:0]    grant_o,
    output logic [PTRW-1:0] idx_o
);

    localparam logic [PTRW:0] NW = (PTRW+1)'(N);

    logic [PTRW:0]   sum;
    logic [PTRW-1:0] j;
    logic            found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        sum     = '0;
        j       = '0;
        for (int unsigned k = 0; k < N; k++) begin
            sum = {1'b0, ptr_i} + (PTRW+1)'(k);
            if (sum >= NW) begin
                sum = sum - NW;
            end
            j = sum[PTRW-1:0];
            if (!found && req_i[j]) begin
                found      = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = j;
            end
        end
    end

endmodule

// File: rtl/io_writeback_arbiter.sv
// Round-robin merge of device writeback responses into a one-entry CPU writeback buffer;
// completion-only responses are acknowledged, dropped and counted.
module io_writeback_arbiter
    import io_pkg::*;
#(
    parameter int unsigned PORTCOUNT     = 4,
    parameter int unsigned DATABITWIDTH  = 16,
    parameter int unsigned DROPCOUNTBITS = 8
) (
    input  logic                                clk,
    input  logic                                sync_rst,
    input  logic                                clk_en,
    input  logic [PORTCOUNT-1:0]                Dev_REQ,
    output logic [PORTCOUNT-1:0]                Dev_ACK,
    input  logic [PORTCOUNT-1:0]                Dev_RegResponseFlag,
    input  logic [PORTCOUNT-1:0]                Dev_MemResponseFlag,
    input  logic [PORTCOUNT*IODESTREGBITS-1:0]  Dev_DestReg,
    input  logic [PORTCOUNT*DATABITWIDTH-1:0]   Dev_Data,
    output logic                                WritebackREQ,
    input  logic                                WritebackACK,
    output logic                                WritebackRegFlag,
    output logic                                WritebackMemFlag,
    output logic [IODESTREGBITS-1:0]            WritebackDestReg,
    output logic [DATABITWIDTH-1:0]             WritebackData,
    output logic [DROPCOUNTBITS-1:0]            DroppedCount
);

    localparam int unsigned PTRW = (PORTCOUNT > 1) ? $clog2(PORTCOUNT) : 1;

    typedef struct packed {
        logic                     RegFlag;
        logic                     MemFlag;
        logic [IODESTREGBITS-1:0] DestReg;
        logic [DATABITWIDTH-1:0]  Data;
    } wb_entry_t;

    wb_buf_state_e            state_q;
    wb_entry_t                buf_q;
    wb_entry_t                sel_d;
    logic [PTRW-1:0]          rr_ptr_q;
    logic [PTRW-1:0]          rr_ptr_d;
    logic [PTRW-1:0]          grant_idx;
    logic [PORTCOUNT-1:0]     grant;
    logic [DROPCOUNTBITS-1:0] drop_cnt_q;
    logic [DROPCOUNTBITS-1:0] drop_cnt_d;
    logic                     accept;
    logic                     xfer;
    logic                     load;
    logic                     drop;
    logic                     drain;

    round_robin_select #(
        .N    (PORTCOUNT),
        .PTRW (PTRW)
    ) u_rr (
        .req_i   (Dev_REQ),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant),
        .idx_o   (grant_idx)
    );

    // A FULL buffer can take a new entry only in the cycle it drains.
    always_comb begin
        accept  = clk_en & ((state_q == BUF_EMPTY) | WritebackACK);
        Dev_ACK = accept ? grant : '0;
        xfer    = accept & (|Dev_REQ);
        drain   = clk_en & (state_q == BUF_FULL) & WritebackACK;

        sel_d.RegFlag = Dev_RegResponseFlag[grant_idx];
        sel_d.MemFlag = Dev_MemResponseFlag[grant_idx];
        sel_d.DestReg = Dev_DestReg[int'(grant_idx)*IODESTREGBITS +: IODESTREGBITS];
        sel_d.Data    = Dev_Data[int'(grant_idx)*DATABITWIDTH +: DATABITWIDTH];

        load = xfer & (sel_d.RegFlag | sel_d.MemFlag);
        drop = xfer & ~(sel_d.RegFlag | sel_d.MemFlag);

        rr_ptr_d   = (grant_idx == PTRW'(PORTCOUNT-1)) ? '0 : grant_idx + 1'b1;
        drop_cnt_d = (drop && (drop_cnt_q != '1)) ? drop_cnt_q + 1'b1 : drop_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q    <= BUF_EMPTY;
            buf_q      <= '0;
            rr_ptr_q   <= '0;
            drop_cnt_q <= '0;
        end else if (clk_en) begin
            if (load) begin
                state_q <= BUF_FULL;
                buf_q   <= sel_d;
            end else if (drain) begin
                state_q <= BUF_EMPTY;
            end
            if (xfer) begin
                rr_ptr_q <= rr_ptr_d;
            end
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign WritebackREQ     = (state_q == BUF_FULL);
    assign WritebackRegFlag = buf_q.RegFlag;
    assign WritebackMemFlag = buf_q.MemFlag;
    assign WritebackDestReg = buf_q.DestReg;
    assign WritebackData    = buf_q.Data;
    assign DroppedCount     = drop_cnt_q;

endmodule

// File: tb/tb_io_writeback_arbiter.sv
// Directed scoreboard bench for io_writeback_arbiter (4 ports, 16-bit data).
module tb_io_writeback_arbiter;

    logic        clk;
    logic        sync_rst;
    logic        clk_en;
    logic [3:0]  Dev_REQ;
    logic [3:0]  Dev_ACK;
    logic [3:0]  Dev_RegResponseFlag;
    logic [3:0]  Dev_MemResponseFlag;
    logic [15:0] Dev_DestReg;
    logic [63:0] Dev_Data;
    logic        WritebackREQ;
    logic        WritebackACK;
    logic        WritebackRegFlag;
    logic        WritebackMemFlag;
    logic [3:0]  WritebackDestReg;
    logic [15:0] WritebackData;
    logic [7:0]  DroppedCount;

    typedef struct {
        logic        r;
        logic        m;
        logic [3:0]  d;
        logic [15:0] data;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    io_writeback_arbiter #(
        .PORTCOUNT     (4),
        .DATABITWIDTH  (16),
        .DROPCOUNTBITS (8)
    ) dut (
        .clk                 (clk),
        .sync_rst            (sync_rst),
        .clk_en              (clk_en),
        .Dev_REQ             (Dev_REQ),
        .Dev_ACK             (Dev_ACK),
        .Dev_RegResponseFlag (Dev_RegResponseFlag),
        .Dev_MemResponseFlag (Dev_MemResponseFlag),
        .Dev_DestReg         (Dev_DestReg),
        .Dev_Data            (Dev_Data),
        .WritebackREQ        (WritebackREQ),
        .WritebackACK        (WritebackACK),
        .WritebackRegFlag    (WritebackRegFlag),
        .WritebackMemFlag    (WritebackMemFlag),
        .WritebackDestReg    (WritebackDestReg),
        .WritebackData       (WritebackData),
        .DroppedCount        (DroppedCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic r, input logic m, input logic [3:0] d, input logic [15:0] data);
        exp_t e;
        e.r = r; e.m = m; e.d = d; e.data = data;
        sbq.push_back(e);
    endtask

    task automatic set_port(input int i, input logic r, input logic m,
                            input logic [3:0] d, input logic [15:0] data);
        Dev_RegResponseFlag[i]  = r;
        Dev_MemResponseFlag[i]  = m;
        Dev_DestReg[4*i +: 4]   = d;
        Dev_Data[16*i +: 16]    = data;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Every CPU-side transfer is compared against the head of the expected queue.
    always @(negedge clk) begin
        if (!sync_rst && clk_en && WritebackREQ && WritebackACK) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wb actual=data %0h expected=none", WritebackData);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("wb_flags", {30'd0, WritebackRegFlag, WritebackMemFlag}, {30'd0, e.r, e.m});
                chk("wb_dest",  {28'd0, WritebackDestReg}, {28'd0, e.d});
                chk("wb_data",  {16'd0, WritebackData}, {16'd0, e.data});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sync_rst = 1'b1;
        clk_en = 1'b1;
        Dev_REQ = '0;
        Dev_RegResponseFlag = '0;
        Dev_MemResponseFlag = '0;
        Dev_DestReg = '0;
        Dev_Data = '0;
        WritebackACK = 1'b0;
        repeat (2) @(posedge clk);
        #1 sync_rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_wbreq", {31'd0, WritebackREQ}, 32'd0);
            chk("idle_data", {16'd0, WritebackData}, 32'd0);
            chk("idle_misc", {14'd0, Dev_ACK, WritebackRegFlag, WritebackMemFlag,
                              WritebackDestReg, DroppedCount}, 32'd0);
        end

        // Single response from port 2
        next_cycle();
        set_port(2, 1'b1, 1'b0, 4'd5, 16'hBEEF);
        Dev_REQ = 4'b0100;
        WritebackACK = 1'b1;
        push_exp(1'b1, 1'b0, 4'd5, 16'hBEEF);
        @(negedge clk);
        chk("p2_ack", {28'd0, Dev_ACK}, 32'h4);
        next_cycle();
        Dev_REQ = '0;
        @(negedge clk);
        chk("p2_wbreq", {31'd0, WritebackREQ}, 32'd1);
        chk("p2_ack_low", {28'd0, Dev_ACK}, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("p2_drained", {31'd0, WritebackREQ}, 32'd0);

        // Reset pulse so the rotation starts from port 0
        next_cycle();
        sync_rst = 1'b1;
        next_cycle();
        sync_rst = 1'b0;

        // All four ports requesting continuously
        for (int i = 0; i < 4; i++) set_port(i, 1'b1, 1'b0, 4'(i), 16'(i));
        Dev_REQ = 4'b1111;
        for (int k = 0; k < 8; k++) push_exp(1'b1, 1'b0, 4'(k % 4), 16'(k % 4));
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("rr_ack", {28'd0, Dev_ACK}, 32'd1 << (k % 4));
            if (k > 0) chk("rr_wbreq", {31'd0, WritebackREQ}, 32'd1);
            next_cycle();
        end
        Dev_REQ = '0;
        @(negedge clk);
        chk("rr_last_wbreq", {31'd0, WritebackREQ}, 32'd1);
        next_cycle();

        // Back-pressure: port 0 buffered, port 1 waits
        set_port(0, 1'b0, 1'b1, 4'hA, 16'hA000);
        set_port(1, 1'b1, 1'b1, 4'hB, 16'hA001);
        Dev_REQ = 4'b0011;
        WritebackACK = 1'b0;
        push_exp(1'b0, 1'b1, 4'hA, 16'hA000);
        push_exp(1'b1, 1'b1, 4'hB, 16'hA001);
        @(negedge clk);
        chk("bp_first_ack", {28'd0, Dev_ACK}, 32'h1);
        next_cycle();
        Dev_REQ = 4'b0010;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_ack_zero", {28'd0, Dev_ACK}, 32'd0);
            chk("bp_wbreq", {31'd0, WritebackREQ}, 32'd1);
            chk("bp_data_stable", {16'd0, WritebackData}, 32'hA000);
            next_cycle();
        end
        clk_en = 1'b0;
        WritebackACK = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("clken_ack_zero", {28'd0, Dev_ACK}, 32'd0);
            chk("clken_wbreq", {31'd0, WritebackREQ}, 32'd1);
            next_cycle();
        end
        clk_en = 1'b1;
        @(negedge clk);
        chk("bp_second_ack", {28'd0, Dev_ACK}, 32'h2);
        next_cycle();
        Dev_REQ = '0;
        @(negedge clk);
        chk("bp_second_wbreq", {31'd0, WritebackREQ}, 32'd1);
        next_cycle();
        @(negedge clk);
        chk("bp_drained", {31'd0, WritebackREQ}, 32'd0);

        // 300 completion-only responses from port 3
        next_cycle();
        set_port(3, 1'b0, 1'b0, 4'd7, 16'h1234);
        Dev_REQ = 4'b1000;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            chk("drop_ack", {28'd0, Dev_ACK}, 32'h8);
            chk("drop_no_wbreq", {31'd0, WritebackREQ}, 32'd0);
            if (k == 1) chk("drop_count_one", {24'd0, DroppedCount}, 32'd1);
            next_cycle();
        end
        Dev_REQ = '0;
        @(negedge clk);
        chk("drop_count_sat", {24'd0, DroppedCount}, 32'd255);

        // Pointer is 0 after the last port-3 drop: port 0 beats port 3
        next_cycle();
        set_port(0, 1'b1, 1'b0, 4'd1, 16'hC000);
        set_port(3, 1'b1, 1'b0, 4'd3, 16'hC003);
        Dev_REQ = 4'b1001;
        push_exp(1'b1, 1'b0, 4'd1, 16'hC000);
        @(negedge clk);
        chk("ptr_after_drop_ack", {28'd0, Dev_ACK}, 32'h1);
        next_cycle();
        set_port(1, 1'b0, 1'b1, 4'd2, 16'hC001);
        Dev_REQ = 4'b0010;
        @(negedge clk);
        chk("pre_rst_ack", {28'd0, Dev_ACK}, 32'h2);

        // Reset with port 1 held in the buffer
        next_cycle();
        Dev_REQ = '0;
        WritebackACK = 1'b0;
        sync_rst = 1'b1;
        @(negedge clk);
        chk("pre_rst_full", {31'd0, WritebackREQ}, 32'd1);
        next_cycle();
        sync_rst = 1'b0;
        set_port(2, 1'b1, 1'b0, 4'd6, 16'hC002);
        Dev_REQ = 4'b0110;
        WritebackACK = 1'b1;
        push_exp(1'b0, 1'b1, 4'd2, 16'hC001);
        @(negedge clk);
        chk("rst_wbreq", {31'd0, WritebackREQ}, 32'd0);
        chk("rst_drop_cnt", {24'd0, DroppedCount}, 32'd0);
        chk("rst_ptr_ack", {28'd0, Dev_ACK}, 32'h2);
        next_cycle();
        Dev_REQ = '0;
        @(negedge clk);
        chk("rst_post_wbreq", {31'd0, WritebackREQ}, 32'd1);
        next_cycle();
        @(negedge clk);
        chk("final_empty", {31'd0, WritebackREQ}, 32'd0);

        chk("sb_empty", sbq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
